// File: rtl/search_if.sv
// Observation port for the integer square-root search.
//
// Output protocol: the result travels on the plain port i. done is a level
// "valid" for that result. It goes high on the edge that completes the
// search and stays high, with i frozen, until reset. There is no ready,
// because the consumer can never stall the search. The remaining fields
// expose the internal registers so that checkers can bind to them directly.
interface search_if;
  logic        done;   // result in i is final (state == DONE)
  logic        state;  // 0 = SEARCH, 1 = DONE
  logic [31:0] hi;     // exclusive upper bound of the search range
  logic [4:0]  iter;   // iterations completed since reset (0..16)

  // The design drives the fields; observers only read them.
  modport master (output done, state, hi, iter);
  modport slave  (input  done, state, hi, iter);
endinterface

// File: rtl/search.sv
// Integer square root by binary search: i converges to floor(sqrt(N)).
// Each clock halves the range [lo, hi). The range starts at width 65536,
// so the search always completes in exactly 16 iterations.
module search #(
  parameter logic [31:0] N = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] i,
  search_if.master    dbg
);

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_DONE   = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_lo;    // candidate root, invariant lo*lo <= N
  logic [31:0] r_hi;    // exclusive bound, hi*hi > N or hi == 65536
  logic [4:0]  r_iter;

  logic [31:0] w_mid;
  logic [31:0] w_sq;
  logic        w_fits;
  logic [31:0] w_lo_nxt;
  logic [31:0] w_hi_nxt;

  // Probe the midpoint. mid never exceeds 65535, so a 32-bit square cannot overflow.
  always_comb begin
    w_mid    = (r_lo + r_hi) >> 1;
    w_sq     = w_mid * w_mid;
    w_fits   = (w_sq <= N);
    w_lo_nxt = w_fits ? w_mid : r_lo;
    w_hi_nxt = w_fits ? r_hi  : w_mid;
  end

  // Search FSM: narrow the range each edge, then freeze in DONE until reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_SEARCH;
      r_lo    <= 32'd0;
      r_hi    <= 32'd65536;
      r_iter  <= 5'd0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          r_lo   <= w_lo_nxt;
          r_hi   <= w_hi_nxt;
          r_iter <= r_iter + 5'd1;
          if ((w_hi_nxt - w_lo_nxt) == 32'd1) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_SEARCH;
        end
      endcase
    end
  end

  // i is taken straight from the lo register, so mid has no combinational path to it.
  assign i         = r_lo;
  assign dbg.done  = (r_state == ST_DONE);
  assign dbg.state = r_state;
  assign dbg.hi    = r_hi;
  assign dbg.iter  = r_iter;

endmodule

// File: tb/tb_search.sv
// Bench for search: twelve instances with different N run side by side.
// A monitor pops the expected root whenever an instance raises done.
module tb_search;

  localparam int NUM = 12;

  // Radicand for each instance.
  function automatic logic [31:0] n_of(input int k);
    case (k)
      0:       return 32'd1000000;
      1:       return 32'd0;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'd2;
      5:       return 32'd3;
      6:       return 32'd4;
      7:       return 32'd15;
      8:       return 32'd16;
      9:       return 32'd17;
      10:      return 32'd65535;
      default: return 32'd65536;
    endcase
  endfunction

  // Roots worked out by hand for the table above.
  function automatic logic [31:0] root_of(input int k);
    case (k)
      0:       return 32'd1000;
      1:       return 32'd0;
      2:       return 32'd65535;
      3:       return 32'd1;
      4:       return 32'd1;
      5:       return 32'd1;
      6:       return 32'd2;
      7:       return 32'd3;
      8:       return 32'd4;
      9:       return 32'd4;
      10:      return 32'd255;
      default: return 32'd256;
    endcase
  endfunction

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_arr    [NUM];
  logic        done_arr [NUM];
  logic [31:0] hi_arr   [NUM];

  generate
    for (genvar g = 0; g < NUM; g++) begin : g_dut
      search_if    u_if ();
      logic [31:0] w_i;
      search #(.N(n_of(g))) u_dut (
        .clock (clock),
        .reset (reset),
        .i     (w_i),
        .dbg   (u_if)
      );
      assign i_arr[g]    = w_i;
      assign done_arr[g] = u_if.done;
      assign hi_arr[g]   = u_if.hi;
    end
  endgenerate

  // Clock and cycle count since reset release.
  always #5 clock = ~clock;

  int unsigned cyc;
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Scoreboard state.
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_all();
    for (int k = 0; k < NUM; k++) exp_q.push_back(root_of(k));
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < NUM; k++) begin
      check({tag, "_i"},    i_arr[k],    0);
      check({tag, "_hi"},   hi_arr[k],   65536);
      check({tag, "_done"}, done_arr[k], 0);
    end
  endtask

  // Monitor: monotonic i during SEARCH; on each rising done, check the root, the latency and the invariant.
  logic        prev_done [NUM];
  logic [31:0] prev_i    [NUM];
  always @(negedge clock) begin
    for (int k = 0; k < NUM; k++) begin
      if (reset) begin
        prev_done[k] = 1'b0;
        prev_i[k]    = 32'd0;
      end else begin
        if (!done_arr[k]) begin
          n_cmp++;
          if (i_arr[k] < prev_i[k]) begin
            n_err++;
            $display("FAIL monotonic[%0d]: got %0d after %0d", k, i_arr[k], prev_i[k]);
          end
        end
        if (done_arr[k] && !prev_done[k]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_done[%0d]: got done with empty queue", k);
          end else begin
            logic [31:0]     e;
            longint unsigned r, nn;
            e  = exp_q.pop_front();
            check($sformatf("root[%0d]", k), i_arr[k], e);
            check($sformatf("latency[%0d]", k), cyc, 16);
            r  = i_arr[k];
            nn = n_of(k);
            check($sformatf("invariant[%0d]", k),
                  ((r * r <= nn) && ((r + 1) * (r + 1) > nn)) ? 1 : 0, 1);
          end
        end
        prev_done[k] = done_arr[k];
        prev_i[k]    = i_arr[k];
      end
    end
  end

  // Stimulus.
  initial begin
    // Run A: hold reset over one edge, then release and run 100 edges.
    @(negedge clock);
    check_reset_values("reset_a");
    push_all();
    #1 reset = 1'b0;
    for (int e = 1; e <= 100; e++) begin
      @(negedge clock);
      check("n0_zero", i_arr[1], 0);
      if (e >= 16) check("n1e6_root", i_arr[0], 1000);
      if (e >= 16 && e <= 26) check("nmax_stable", i_arr[2], 65535);
    end
    check("queue_drained_a", exp_q.size(), 0);

    // Run B: restart, abort with an asynchronous reset mid-clock after 8 edges, then rerun.
    @(negedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_values("reset_b");
    #1 reset = 1'b0;
    repeat (8) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_reset_values("async_abort");
    @(negedge clock);
    push_all();
    #1 reset = 1'b0;
    repeat (16) @(negedge clock);
    check("restart_root", i_arr[0], 1000);
    repeat (4) @(negedge clock);
    check("queue_drained_b", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
